// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational 32-bit ALU between two clients. A round-robin
// arbiter picks one request while idle. The winning operands are registered
// onto the ALU input ports. The ALU outputs are sampled one cycle later, and
// the result is returned on a single tagged response channel. Illegal opcodes
// are never executed. They return an error response straight away.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. reqN_ready is combinational from the valids and the state,
// so clients must not wait for ready before raising valid. rsp_valid and all
// rsp_* / alu_* outputs stay stable until the cycle where rsp_ready is high.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           request handshake for client N (0, 1)
//   reqN_a, reqN_b, reqN_op    operands and 4-bit ALU opcode for client N
//   rsp_valid/ready            response handshake
//   rsp_id                     client that owns the response
//   rsp_result/zero/cout       ALU result and flags (0 on error)
//   rsp_err                    illegal opcode; nothing was issued
//   alu_a, alu_b, alu_op       registered operands to the ALU
//   alu_result/zero/cout       combinational outputs of the ALU
//   busy                       controller is not idle
//   op_count                   completed responses, wraps
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_cout,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              last_grant_q, last_grant_d;

    // Arbitration (only meaningful in IDLE)
    logic              any_req;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [3:0]        sel_op;
    logic              sel_legal;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_is_legal = 1'b1;
            default:                                             op_is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        any_req = req0_valid | req1_valid;
        // On a tie, the client that did not win last time gets the grant.
        // A lone requester always wins.
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        sel_a     = grant_id ? req1_a  : req0_a;
        sel_b     = grant_id ? req1_b  : req0_b;
        sel_op    = grant_id ? req1_op : req0_op;
        sel_legal = op_is_legal(sel_op);
    end

    // Ready is also gated by rst_n so it stays low for the whole reset hold,
    // including the very first cycle before the state register is cleared.
    assign req0_ready = rst_n && (state_q == IDLE) && any_req && !grant_id;
    assign req1_ready = rst_n && (state_q == IDLE) && any_req &&  grant_id;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                    rsp_id_d = grant_id;
                    if (sel_legal) begin
                        state_d = EXEC;
                    end else begin
                        // The ALU still sees the illegal opcode, but its
                        // outputs are never sampled. Respond with an error.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_cout_d   = 1'b0;
                        state_d      = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_cout_d   = alu_cout;
                rsp_err_d    = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
            last_grant_q <= 1'b1;   // so client 0 wins the first tie
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Bench for alu_share_ctrl. A behavioural 32-bit ALU sits on the alu_* ports.
// On illegal opcodes it drives deliberately non-zero garbage, so any leak of
// ALU outputs into an error response is visible. The counter width is reduced
// to 4 bits so that the wrap-around can be reached in a few operations.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    req0_op, req1_op;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_cout, rsp_err;
    logic [DW-1:0] rsp_result;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [3:0]    alu_op;
    logic          alu_zero, alu_cout, busy;
    logic [CW-1:0] op_count;

    alu_share_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout),
        .busy       (busy),
        .op_count   (op_count)
    );

    // ---------------- reference ALU ----------------
    // Returns {zero, cout, result}. Illegal opcodes give garbage on purpose.
    function automatic logic [33:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] res;
        logic        co;
        co = 1'b0;
        s  = '0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin s = {1'b0, a} + {1'b0, b};          res = s[31:0]; co = s[32]; end
            4'b0110: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; res = s[31:0]; co = s[32]; end
            4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            default: return {2'b11, a ^ b ^ 32'hDEAD_BEEF};
        endcase
        return {(res == 32'd0), co, res};
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
               (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1100);
    endfunction

    // Expected response packed as {id, err, zero, cout, result}
    function automatic logic [35:0] expect_rsp(input int c, input logic [31:0] a,
                                               input logic [31:0] b, input logic [3:0] op);
        logic [33:0] r;
        if (op_legal(op)) begin
            r = alu_eval(a, b, op);
            return {c[0], 1'b0, r[33], r[32], r[31:0]};
        end
        return {c[0], 1'b1, 34'd0};
    endfunction

    logic [33:0] alu_out;
    always_comb alu_out = alu_eval(alu_a, alu_b, alu_op);
    assign alu_result = alu_out[31:0];
    assign alu_cout   = alu_out[32];
    assign alu_zero   = alu_out[33];

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait for its grant. Returns just after the
    // handshake edge (cycle T+1), with the client's valid dropped.
    task automatic send(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        bit done;
        done = 1'b0;
        if (c == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if ((c == 0 && req0_ready === 1'b1) || (c == 1 && req1_ready === 1'b1)) begin
                exp_q.push_back(expect_rsp(c, a, b, op));
                done = 1'b1;
            end
            tick();
        end
        if (c == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        check("send_granted", done, 1);
    endtask

    // Wait for rsp_valid, compare against the scoreboard head, then complete
    // the response handshake. lat = cycles waited after entry.
    task automatic recv(input int max_wait, output int lat);
        bit          got;
        logic [35:0] exp;
        got = 1'b0;
        lat = 0;
        while (!got && lat < max_wait) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check("rsp_seen", got, 1);
        if (got) begin
            check("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("rsp_fields", {rsp_id, rsp_err, rsp_zero, rsp_cout, rsp_result}, exp);
            end
            rsp_ready = 1'b1;
            tick();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        int          g;
        bit          got;
        int          c;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'h1;         req1_b = 32'h2;         req1_op = 4'b0001;

        // Reset default: both valids held high, nothing accepted
        tick();
        tick();
        check("reset_ctrl", {rsp_valid, busy, req0_ready, req1_ready,
                             rsp_id, rsp_err, rsp_zero, rsp_cout}, 8'h00);
        check("reset_op_count", op_count, 0);
        check("reset_alu_ab", {alu_a, alu_b}, 64'h0);
        check("reset_alu_op", alu_op, 0);
        check("reset_result", rsp_result, 0);
        rst_n = 1'b1;
        #1;
        check("first_tie_ready0", req0_ready, 1);
        check("first_tie_ready1", req1_ready, 0);
        req1_valid = 1'b0;
        send(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000);
        recv(5, lat);
        check("and_latency", lat, 1);

        // Single ADD from client 1
        send(1, 32'h7FFF_FFFF, 32'h1, 4'b0010);
        check("add_alu_a_t1", alu_a, 32'h7FFF_FFFF);
        check("add_no_rsp_t1", rsp_valid, 0);
        check("add_busy_t1", busy, 1);
        tick();
        check("add_rsp_valid_t2", rsp_valid, 1);
        check("add_result", {rsp_id, rsp_err, rsp_zero, rsp_result}, {3'b100, 32'h8000_0000});
        recv(5, lat);
        check("add_latency", lat, 0);
        check("add_op_count", op_count, 2);
        check("add_idle_t3", busy, 0);

        // Round robin under contention, last grant was client 1
        req0_a = 32'd5; req0_b = 32'd5; req0_op = 4'b0110;
        req1_a = 32'd3; req1_b = 32'd7; req1_op = 4'b0111;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g   = i % 2;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                #1;
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    got = 1'b1;
                    check("rr_ready0", req0_ready, (g == 0));
                    check("rr_ready1", req1_ready, (g == 1));
                    if (g == 0) exp_q.push_back(expect_rsp(0, req0_a, req0_b, req0_op));
                    else        exp_q.push_back(expect_rsp(1, req1_a, req1_b, req1_op));
                end
                tick();
            end
            check("rr_granted", got, 1);
            check("rr_exec_no_ready", {req0_ready, req1_ready}, 0);
            recv(5, lat);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_op_count", op_count, 6);

        // Illegal opcode: immediate error response
        send(0, 32'h1234, 32'h5678, 4'b1111);
        check("ill_rsp_valid_t1", rsp_valid, 1);
        check("ill_alu_op", alu_op, 4'hF);
        check("ill_fields", {rsp_err, rsp_zero, rsp_cout, rsp_result}, {3'b100, 32'h0});
        recv(5, lat);
        check("ill_latency", lat, 0);
        check("ill_op_count", op_count, 7);

        // Backpressure: 5 cycles in RESP without rsp_ready
        rsp_ready = 1'b0;
        send(1, 32'd10, 32'd3, 4'b0110);
        tick();
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp", {rsp_id, rsp_err, rsp_result}, {2'b10, 32'd7});
            check("bp_alu", {alu_a, alu_b, 28'h0, alu_op}, {32'd10, 32'd3, 32'd6} >> 0);
            check("bp_no_ready", {req0_ready, req1_ready}, 0);
            tick();
        end
        req0_valid = 1'b0;
        recv(2, lat);
        check("bp_idle", busy, 0);
        check("bp_op_count", op_count, 8);

        // Mid-operation reset during EXEC
        send(0, 32'd1, 32'd2, 4'b0010);
        check("mid_busy_exec", busy, 1);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("mid_reset_ctrl", {rsp_valid, busy, req0_ready, req1_ready,
                                 rsp_id, rsp_err, rsp_zero, rsp_cout}, 8'h00);
        check("mid_reset_alu", {alu_a, alu_b}, 64'h0);
        check("mid_reset_op", {alu_op, rsp_result}, 36'h0);
        check("mid_reset_count", op_count, 0);
        rst_n = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_tie_ready0", req0_ready, 1);
        check("mid_tie_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_rsp", rsp_valid, 0);
        end

        // Random traffic up to the counter wrap (4-bit counter here)
        for (int i = 0; i < 16; i++) begin
            c   = int'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? ra : $urandom;
            rop = 4'($urandom_range(0, 15));
            send(c, ra, rb, rop);
            recv(5, lat);
            if (i == 14) check("wrap_max", op_count, 4'hF);
            if (i == 15) check("wrap_zero", op_count, 4'h0);
        end
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
